// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO slice: depth/pointer-width helpers and
// the common reset value used for masked read data.
package fifo_pkg;

    // Reset/idle value bit, replicated to the data width where used
    localparam logic IPS_RST_DATA = 1'b0;

    // Number of words held by a buffer addressed with n bits
    function automatic int ips_depth(input int n);
        return 32'sd1 <<< n;
    endfunction

    // Pointer width: one extra bit beyond the address distinguishes full from empty
    function automatic int ips_ptr_w(input int n);
        return n + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping (FIFO_SIZE+1)-bit pointer used for both the write and read side
// of the FIFO. It advances by one per accepted transfer.
module fifo_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] ptr_r;

    // Advance by one on each transfer; wraps naturally modulo 2**PTR_W
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (i_inc) begin
            ptr_r <= ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign o_ptr = ptr_r;

endmodule

// File: rtl/fifo.sv
// Circular first-word-fall-through FIFO with valid/ready on both sides.
// Optional registered fill level on o_level when FIFO_LEVEL_EN is defined.
module fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 18,
    parameter int FIFO_SIZE  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [FIFO_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [FIFO_WIDTH-1:0] o_rd_data
`ifdef FIFO_LEVEL_EN
    ,
    output logic [FIFO_SIZE:0]    o_level
`endif
);

    localparam int DEPTH = ips_depth(FIFO_SIZE);
    localparam int PTR_W = ips_ptr_w(FIFO_SIZE);

    logic [FIFO_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (wr_fire_s),
        .o_ptr   (wr_ptr_s)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (rd_fire_s),
        .o_ptr   (rd_ptr_s)
    );

    // Flags come only from registered pointers, so valid/ready never loop back
    always_comb begin
        empty_s   = (wr_ptr_s == rd_ptr_s);
        full_s    = (wr_ptr_s[PTR_W-1] != rd_ptr_s[PTR_W-1]) &&
                    (wr_ptr_s[PTR_W-2:0] == rd_ptr_s[PTR_W-2:0]);
        wr_fire_s = i_wr_valid && !full_s;
        rd_fire_s = i_rd_ready && !empty_s;
    end

    assign o_wr_ready = !full_s;
    assign o_rd_valid = !empty_s;

    // Fall-through read port, held at the idle value while nothing is stored
    always_comb begin
        if (empty_s) begin
            o_rd_data = {FIFO_WIDTH{IPS_RST_DATA}};
        end else begin
            o_rd_data = mem_r[rd_ptr_s[PTR_W-2:0]];
        end
    end

    // Storage write; contents are intentionally not cleared by reset
    always_ff @(posedge i_clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_s[PTR_W-2:0]] <= i_wr_data;
        end
    end

`ifdef FIFO_LEVEL_EN
    logic [FIFO_SIZE:0] level_r;

    // Track words stored; moves on the same edge as the pointers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_r <= {(FIFO_SIZE+1){1'b0}};
        end else begin
            case ({wr_fire_s, rd_fire_s})
                2'b10:   level_r <= level_r + {{FIFO_SIZE{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{FIFO_SIZE{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    assign o_level = level_r;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo (FIFO_WIDTH=18, FIFO_SIZE=2): directed steps
// plus randomized traffic compared against a queue-based reference.
module tb_fifo;

    localparam int W     = 18;
    localparam int SZ    = 2;
    localparam int DEPTH = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [W-1:0]  i_wr_data;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [W-1:0]  o_rd_data;
`ifdef FIFO_LEVEL_EN
    logic [SZ:0]   o_level;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model_q[$];

    fifo #(.FIFO_WIDTH(W), .FIFO_SIZE(SZ)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_data  (i_wr_data),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready),
        .o_rd_data  (o_rd_data)
`ifdef FIFO_LEVEL_EN
        ,
        .o_level    (o_level)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue
    task automatic check_outs(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, "_rd_valid"}, {31'd0, o_rd_valid}, (sz != 0) ? 32'd1 : 32'd0);
        chk({tag, "_wr_ready"}, {31'd0, o_wr_ready}, (sz != DEPTH) ? 32'd1 : 32'd0);
        chk({tag, "_rd_data"}, {14'd0, o_rd_data}, (sz != 0) ? {14'd0, model_q[0]} : 32'd0);
`ifdef FIFO_LEVEL_EN
        chk({tag, "_level"}, {29'd0, o_level}, sz);
`endif
    endtask

    // One clock: check at the falling edge, drive, then update the model at the rising edge
    task automatic cycle(input string tag, input logic wv, input logic [W-1:0] wd, input logic rv);
        int  sz;
        logic wf;
        logic rf;
        check_outs(tag);
        i_wr_valid = wv;
        i_wr_data  = wd;
        i_rd_ready = rv;
        @(posedge i_clk);
        sz = model_q.size();
        wf = wv && (sz < DEPTH);
        rf = rv && (sz > 0);
        if (rf) void'(model_q.pop_front());
        if (wf) model_q.push_back(wd);
        @(negedge i_clk);
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        i_wr_data  = '0;
        #1;
        check_outs("reset_init");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Ordering
        for (int i = 1; i <= 3; i++) cycle("ord_wr", 1'b1, W'(i), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("ord_data", {14'd0, o_rd_data}, i);
            cycle("ord_rd", 1'b0, '0, 1'b1);
        end
        chk("ord_empty", {31'd0, o_rd_valid}, 32'd0);

        // Full and dropped fifth write
        for (int i = 0; i < 4; i++) cycle("full_wr", 1'b1, W'(32'h10 + i), 1'b0);
        chk("full_wr_ready", {31'd0, o_wr_ready}, 32'd0);
`ifdef FIFO_LEVEL_EN
        chk("full_level", {29'd0, o_level}, 32'd4);
`endif
        cycle("full_drop", 1'b1, W'(32'h14), 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("full_data", {14'd0, o_rd_data}, 32'h10 + i);
            cycle("full_rd", 1'b0, '0, 1'b1);
        end
        chk("full_after", {31'd0, o_rd_valid}, 32'd0);

        // Full with simultaneous read and write: only the read fires
        for (int i = 0; i < 4; i++) cycle("fs_wr", 1'b1, W'(32'h10 + i), 1'b0);
        chk("fs_head", {14'd0, o_rd_data}, 32'h10);
        cycle("fs_both", 1'b1, W'(32'h99), 1'b1);
        chk("fs_wr_ready", {31'd0, o_wr_ready}, 32'd1);
        chk("fs_head2", {14'd0, o_rd_data}, 32'h11);
`ifdef FIFO_LEVEL_EN
        chk("fs_level", {29'd0, o_level}, 32'd3);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("fs_data", {14'd0, o_rd_data}, 32'h11 + i);
            cycle("fs_rd", 1'b0, '0, 1'b1);
        end

        // Wrap: continuous write+read from 0x20
        for (int i = 0; i < 10; i++) cycle("wrap", 1'b1, W'(32'h20 + i), 1'b1);
        chk("wrap_last", {14'd0, o_rd_data}, 32'h29);
        cycle("wrap_drain", 1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-stream
        cycle("rst_pre", 1'b1, W'(32'h3abcd), 1'b0);
        cycle("rst_pre", 1'b1, W'(32'h12345), 1'b0);
        i_wr_valid = 1'b1;
        i_wr_data  = W'(32'h2aaaa);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_q.delete();
        check_outs("rst_async");
        @(negedge i_clk);
        check_outs("rst_hold");
        i_wr_valid = 1'b0;
        i_rst_n    = 1'b1;
        @(negedge i_clk);
        cycle("post_rst", 1'b1, W'(32'h00777), 1'b0);
        chk("post_rst_data", {14'd0, o_rd_data}, 32'h777);
        cycle("post_rst_rd", 1'b0, '0, 1'b1);
        check_outs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
